cache_traffic_gen: RTL and testbench

CACHE_TRAFFIC_GEN -- requirements
Module: cache_traffic_gen

---
 rtl/cache_traffic_gen.sv | 150 +++++++++++++++
 tb/tb_cache_traffic_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cache_traffic_gen.sv
// cache_traffic_gen: replays a small script of CPU read/write requests
// against a cache and counts stalls. Defining TRAFFIC_CHECK_EN adds
// read-data checking (err_cnt, first_err_idx); without it both are tied to 0.
module cache_traffic_gen #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CW    = 16,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          prog_we,
  input  logic [IW-1:0] prog_idx,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  input  logic          prog_rw,
  input  logic          start,
  input  logic [IW:0]   count,
  input  logic          loop,
  input  logic          stop,
  output logic          req_valid,
  output logic [AW-1:0] req_addr,
  output logic [DW-1:0] req_data,
  output logic          req_rw,
  input  logic          cpu_ready,
  input  logic [DW-1:0] cpu_rdata,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] cur_idx,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [IW-1:0] first_err_idx
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [IW:0] MAXC = (IW + 1)'(DEPTH);

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic          mem_rw   [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [IW-1:0] cur_idx_q, cur_idx_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [CW-1:0] stall_q, stall_d;
  logic          run, go, last;

  assign run  = state_q == RUN;
  assign go   = !run && start && count != '0 && count <= MAXC;
  assign last = {1'b0, cur_idx_q} == cnt_q - 1'b1;

  assign req_valid = run;
  assign req_addr  = run ? mem_addr[cur_idx_q] : '0;
  assign req_data  = run ? mem_data[cur_idx_q] : '0;
  assign req_rw    = run ? mem_rw[cur_idx_q] : 1'b0;
  assign busy      = run;
  assign done      = done_q;
  assign cur_idx   = cur_idx_q;
  assign stall_cnt = stall_q;

  // Script RAM: loadable only while no run is in progress; not reset.
  always_ff @(posedge clk) begin
    if (prog_we && !run) begin
      mem_addr[prog_idx] <= prog_addr;
      mem_data[prog_idx] <= prog_data;
      mem_rw[prog_idx]   <= prog_rw;
    end
  end

  // Run control: start/stop, entry sequencing, wrap, sticky done, stall count.
  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    stall_d   = stall_q;
    if (!run) begin
      if (go) begin
        state_d   = RUN;
        cur_idx_d = '0;
        cnt_d     = count;
        done_d    = 1'b0;
        stall_d   = '0;
      end else if (start) begin
        done_d = 1'b1;
      end
    end else begin
      if (!cpu_ready) stall_d = &stall_q ? stall_q : stall_q + 1'b1;
      if (stop || (cpu_ready && last && !loop)) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else if (cpu_ready) begin
        cur_idx_d = last ? '0 : cur_idx_q + 1'b1;
      end
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      cur_idx_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      stall_q   <= stall_d;
    end
  end

`ifdef TRAFFIC_CHECK_EN
  logic [CW-1:0] err_q, err_d;
  logic [IW-1:0] ferr_q, ferr_d;
  assign err_cnt       = err_q;
  assign first_err_idx = ferr_q;

  // Read-data check: count mismatching read completions, remember the first.
  always_comb begin
    err_d  = err_q;
    ferr_d = ferr_q;
    if (go) begin
      err_d  = '0;
      ferr_d = '0;
    end else if (run && cpu_ready && !mem_rw[cur_idx_q] && cpu_rdata != mem_data[cur_idx_q]) begin
      err_d  = &err_q ? err_q : err_q + 1'b1;
      ferr_d = err_q == '0 ? cur_idx_q : ferr_q;
    end
  end

  // Check result registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err_q  <= '0;
      ferr_q <= '0;
    end else begin
      err_q  <= err_d;
      ferr_q <= ferr_d;
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata  = ^cpu_rdata;
  assign err_cnt       = '0;
  assign first_err_idx = '0;
`endif
endmodule

// File: tb/tb_cache_traffic_gen.sv
// tb_cache_traffic_gen: directed and randomized runs of cache_traffic_gen
// checked against a queue-based model of the expected request stream.
`define CK(t, o, e) chk(t, 64'(o), 64'(e))
module tb_cache_traffic_gen;
`ifdef TRAFFIC_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  logic        clk = 1'b0, clr_n = 1'b0;
  logic        prog_we = 1'b0, prog_rw = 1'b0;
  logic [2:0]  prog_idx = '0;
  logic [31:0] prog_addr = '0, prog_data = '0;
  logic        start = 1'b0, loop = 1'b0, stop = 1'b0;
  logic [3:0]  count = '0;
  logic        req_valid, req_rw, cpu_ready = 1'b0, busy, done;
  logic [31:0] req_addr, req_data, cpu_rdata = '0;
  logic [2:0]  cur_idx, first_err_idx;
  logic [15:0] stall_cnt, err_cnt;
  logic [31:0] s_addr [8], s_data [8];
  logic        s_rw [8];
  int          n_chk = 0, n_pass = 0;

  cache_traffic_gen dut (
    .clk(clk), .clr_n(clr_n), .prog_we(prog_we), .prog_idx(prog_idx),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_rw(prog_rw),
    .start(start), .count(count), .loop(loop), .stop(stop),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_rw(req_rw),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .busy(busy), .done(done),
    .cur_idx(cur_idx), .stall_cnt(stall_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int i, input logic [31:0] a, input logic [31:0] d, input logic rw);
    prog_we = 1'b1; prog_idx = i[2:0]; prog_addr = a; prog_data = d; prog_rw = rw;
    s_addr[i] = a; s_data[i] = d; s_rw[i] = rw;
    tick;
    prog_we = 1'b0;
  endtask

  task automatic load_base;
    prog(0, 32'h0, 32'h0AB2112A, 1'b0);
    prog(1, 32'h4, $urandom, 1'b0);
    prog(2, 32'h0, $urandom, 1'b0);
    prog(3, 32'h10, 32'h0AB21123, 1'b1);
    prog(4, 32'h10, 32'h0AB21123, 1'b0);
    for (int i = 5; i < 8; i++) prog(i, $urandom & 32'hFFFC, $urandom, 1'($urandom_range(1)));
  endtask

  // One non-looping run: expected entries queued up front, popped on each ready cycle.
  task automatic run(input int cnt, input int pct, input int sidx, input int sn, input int bad);
    int q[$];
    int e, stalls, held, errs, ferr, bound;
    logic rdy;
    stalls = 0; held = 0; errs = 0; ferr = 0; bound = 0;
    for (int i = 0; i < cnt; i++) q.push_back(i);
    start = 1'b1; count = cnt[3:0]; loop = 1'b0;
    tick;
    start = 1'b0;
    while (q.size() > 0 && bound < 500) begin
      e = q[0];
      `CK("req_valid", req_valid, 1'b1);
      `CK("busy", busy, 1'b1);
      `CK("req_addr", req_addr, s_addr[e]);
      `CK("req_data", req_data, s_data[e]);
      `CK("req_rw", req_rw, s_rw[e]);
      `CK("cur_idx", cur_idx, e);
      rdy = (e == sidx && held < sn) ? 1'b0 : ($urandom_range(99) < pct);
      if (e == sidx && !rdy) held++;
      cpu_ready = rdy;
      cpu_rdata = (e == bad) ? 32'hDEADBEEF : s_data[e];
      if (!rdy) stalls++;
      else begin
        if (!s_rw[e] && cpu_rdata != s_data[e]) begin
          if (errs == 0) ferr = e;
          errs++;
        end
        void'(q.pop_front());
      end
      tick;
      bound++;
    end
    cpu_ready = 1'b0;
    `CK("run_finished_in_bound", bound < 500, 1'b1);
    `CK("end_done", done, 1'b1);
    `CK("end_busy", busy, 1'b0);
    `CK("end_req_valid", req_valid, 1'b0);
    `CK("end_req_addr", req_addr, 32'h0);
    `CK("end_cur_idx", cur_idx, cnt - 1);
    `CK("stall_cnt", stall_cnt, stalls);
    `CK("err_cnt", err_cnt, CHECK ? errs : 0);
    `CK("first_err_idx", first_err_idx, CHECK ? ferr : 0);
  endtask

  initial begin
    tick;
    tick;
    `CK("rst_req_valid", req_valid, 1'b0);
    `CK("rst_busy", busy, 1'b0);
    `CK("rst_done", done, 1'b0);
    `CK("rst_cur_idx", cur_idx, 0);
    `CK("rst_stall_cnt", stall_cnt, 0);
    `CK("rst_err_cnt", err_cnt, 0);
    `CK("rst_first_err_idx", first_err_idx, 0);
    `CK("rst_req_addr", req_addr, 32'h0);
    clr_n = 1'b1;
    load_base;
    run(5, 100, -1, 0, -1);
    run(5, 100, 1, 3, -1);
    run(5, 100, -1, 0, 4);
    // Looping run with a script write attempted mid-run, then stop together with start.
    loop = 1'b1; start = 1'b1; count = 4'd2; cpu_ready = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      `CK("loop_valid", req_valid, 1'b1);
      `CK("loop_addr", req_addr, s_addr[k % 2]);
      `CK("loop_idx", cur_idx, k % 2);
      cpu_rdata = s_data[k % 2];
      prog_we = (k == 2); prog_idx = 3'd1; prog_addr = 32'hBAD0; prog_rw = 1'b1;
      tick;
    end
    prog_we = 1'b0; stop = 1'b1; start = 1'b1; cpu_rdata = s_data[0];
    tick;
    stop = 1'b0; start = 1'b0; loop = 1'b0; cpu_ready = 1'b0;
    `CK("stop_done", done, 1'b1);
    `CK("stop_req_valid", req_valid, 1'b0);
    `CK("stop_busy", busy, 1'b0);
    `CK("stop_stall_cnt", stall_cnt, 0);
    `CK("stop_err_cnt", err_cnt, 0);
    // Randomized scripts and runs.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) prog(i, $urandom & 32'hFFFC, $urandom, 1'($urandom_range(1)));
      run($urandom_range(1, 8), $urandom_range(40, 100), $urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 7));
    end
    // Reset mid-run at entry 2.
    load_base;
    start = 1'b1; count = 4'd5; cpu_ready = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    `CK("pre_rst_idx", cur_idx, 2);
    clr_n = 1'b0;
    #1;
    `CK("async_rst_valid", req_valid, 1'b0);
    `CK("async_rst_busy", busy, 1'b0);
    `CK("async_rst_idx", cur_idx, 0);
    `CK("async_rst_done", done, 1'b0);
    cpu_ready = 1'b0;
    tick;
    clr_n = 1'b1;
    start = 1'b1; count = 4'd0;
    tick;
    start = 1'b0;
    `CK("cnt0_done", done, 1'b1);
    `CK("cnt0_valid", req_valid, 1'b0);
    `CK("cnt0_busy", busy, 1'b0);
    tick;
    `CK("cnt0_stays_idle", req_valid, 1'b0);
    start = 1'b1; count = 4'd9;
    tick;
    start = 1'b0;
    `CK("cnt9_valid", req_valid, 1'b0);
    `CK("cnt9_done", done, 1'b1);
    load_base;
    run(5, 70, -1, 0, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
